// File: rtl/w5300_socket_scheduler.sv
// Bus owner for the W5300 driver: services socket interrupts (IR -> Sn_IR read/clear -> event)
// and arbitrates per-socket engines round-robin, guarded by a bus watchdog.
module w5300_socket_scheduler #(
  parameter int N_SOCKETS  = 4,
  parameter int CLK_FREQ   = 100,
  parameter int TIMEOUT_US = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_done,
  input  logic                      int_n,
  output logic [10:0]               ctrl_addr,
  output logic [15:0]               ctrl_wr_data,
  input  logic [15:0]               ctrl_rd_data,
  input  logic                      ctrl_op_state,
  input  logic [N_SOCKETS-1:0]      eng_req,
  input  logic [N_SOCKETS-1:0]      eng_done,
  input  logic [N_SOCKETS*11-1:0]   eng_addr,
  input  logic [N_SOCKETS*16-1:0]   eng_wr_data,
  output logic [N_SOCKETS-1:0]      eng_grant,
  output logic                      sock_event_valid,
  output logic [2:0]                sock_event_idx,
  output logic [4:0]                sock_event_flags,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int TIMEOUT = TIMEOUT_US * CLK_FREQ;

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_RD_IR     = 3'd2;
  localparam logic [2:0] S_RD_SNIR   = 3'd3;
  localparam logic [2:0] S_CLR_SNIR  = 3'd4;
  localparam logic [2:0] S_GRANT     = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [9:0] IDLE_REG = 10'h3fe;
  localparam logic [9:0] IR_REG   = 10'h002;

  logic [2:0]           state;
  logic [N_SOCKETS-1:0] pending;
  logic [2:0]           idx;
  logic [4:0]           flags;
  logic [2:0]           sel;
  logic [2:0]           rr;
  logic [31:0]          wd_cnt;

  logic [N_SOCKETS-1:0] gnt_vec;
  logic [N_SOCKETS-1:0] pending_left;
  logic [9:0]           snir_reg;
  logic [10:0]          sel_addr;
  logic [15:0]          sel_wr;
  logic                 done_hit;

  function automatic logic [2:0] lowest_bit(input logic [N_SOCKETS-1:0] v);
    lowest_bit = '0;
    for (int i = N_SOCKETS - 1; i >= 0; i--)
      if (v[i]) lowest_bit = 3'(i);
  endfunction

  // First requester at or above ptr, wrapping modulo N_SOCKETS.
  function automatic logic [2:0] rr_pick(input logic [N_SOCKETS-1:0] req, input logic [2:0] ptr);
    int j;
    rr_pick = ptr;
    for (int k = N_SOCKETS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_SOCKETS) j = j - N_SOCKETS;
      if (req[j]) rr_pick = 3'(j);
    end
  endfunction

  assign gnt_vec      = {{(N_SOCKETS-1){1'b0}}, 1'b1} << sel;
  assign pending_left = pending & ~({{(N_SOCKETS-1){1'b0}}, 1'b1} << idx);
  assign snir_reg     = 10'h206 + (10'(idx) << 6);
  assign done_hit     = (state == S_GRANT) && |(eng_done & gnt_vec);
  assign busy         = !(state == S_WAIT_INIT || state == S_IDLE);

  always_comb begin
    sel_addr = '0;
    sel_wr   = '0;
    for (int i = 0; i < N_SOCKETS; i++) begin
      if (sel == 3'(i)) begin
        sel_addr = eng_addr[11*i +: 11];
        sel_wr   = eng_wr_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    ctrl_addr    = {1'b1, IDLE_REG};
    ctrl_wr_data = '0;
    eng_grant    = '0;
    case (state)
      S_RD_IR:    ctrl_addr = {1'b1, IR_REG};
      S_RD_SNIR:  ctrl_addr = {1'b1, snir_reg};
      S_CLR_SNIR: begin
        ctrl_addr    = {1'b0, snir_reg};
        ctrl_wr_data = {11'd0, flags};
      end
      S_GRANT: begin
        ctrl_addr    = sel_addr;
        ctrl_wr_data = sel_wr;
        eng_grant    = gnt_vec;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_WAIT_INIT;
      pending          <= '0;
      idx              <= '0;
      flags            <= '0;
      sel              <= '0;
      rr               <= '0;
      wd_cnt           <= '0;
      err              <= 1'b0;
      sock_event_valid <= 1'b0;
      sock_event_idx   <= '0;
      sock_event_flags <= '0;
    end else begin
      sock_event_valid <= 1'b0;
      case (state)
        S_WAIT_INIT: if (init_done) state <= S_IDLE;
        S_IDLE: begin
          if (!int_n) begin
            state <= S_RD_IR;
          end else if (|eng_req) begin
            sel   <= rr_pick(eng_req, rr);
            state <= S_GRANT;
          end
        end
        S_RD_IR: begin
          if (ctrl_op_state) begin
            pending <= ctrl_rd_data[N_SOCKETS-1:0];
            idx     <= lowest_bit(ctrl_rd_data[N_SOCKETS-1:0]);
            state   <= (|ctrl_rd_data[N_SOCKETS-1:0]) ? S_RD_SNIR : S_IDLE;
          end
        end
        S_RD_SNIR: begin
          if (ctrl_op_state) begin
            flags <= ctrl_rd_data[4:0];
            state <= S_CLR_SNIR;
          end
        end
        S_CLR_SNIR: begin
          // The event is reported only once the clear-write has landed.
          if (ctrl_op_state) begin
            sock_event_valid <= 1'b1;
            sock_event_idx   <= idx;
            sock_event_flags <= flags;
            pending          <= pending_left;
            if (|pending_left) begin
              idx   <= lowest_bit(pending_left);
              state <= S_RD_SNIR;
            end else begin
              state <= int_n ? S_IDLE : S_RD_IR;
            end
          end
        end
        S_GRANT: begin
          if (done_hit) begin
            rr    <= (sel == 3'(N_SOCKETS - 1)) ? 3'd0 : sel + 3'd1;
            state <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (err_clr) begin
            err   <= 1'b0;
            state <= S_WAIT_INIT;
          end
        end
        default: state <= S_WAIT_INIT;
      endcase

      // Watchdog overrides the FSM when a bus op or grant stalls.
      if (state == S_WAIT_INIT || state == S_IDLE || state == S_ERROR || ctrl_op_state || done_hit) begin
        wd_cnt <= '0;
      end else if (wd_cnt == 32'(TIMEOUT - 1)) begin
        wd_cnt <= '0;
        err    <= 1'b1;
        state  <= S_ERROR;
      end else begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_w5300_socket_scheduler.sv
// Directed bench for w5300_socket_scheduler: IRQ service sequence, round-robin grants,
// IRQ priority, out-of-range IR bits and the bus watchdog.
module tb_w5300_socket_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           init_done;
  logic           int_n;
  logic [10:0]    ctrl_addr;
  logic [15:0]    ctrl_wr_data;
  logic [15:0]    ctrl_rd_data;
  logic           ctrl_op_state;
  logic [N-1:0]   eng_req;
  logic [N-1:0]   eng_done;
  logic [N*11-1:0] eng_addr;
  logic [N*16-1:0] eng_wr_data;
  logic [N-1:0]   eng_grant;
  logic           sock_event_valid;
  logic [2:0]     sock_event_idx;
  logic [4:0]     sock_event_flags;
  logic           busy;
  logic           err;
  logic           err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] ev_idx_log[16];
  logic [4:0] ev_flag_log[16];
  int         ev_n = 0;

  always #5 clk = ~clk;

  w5300_socket_scheduler #(.N_SOCKETS(N), .CLK_FREQ(100), .TIMEOUT_US(60)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .int_n(int_n),
    .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_rd_data(ctrl_rd_data),
    .ctrl_op_state(ctrl_op_state), .eng_req(eng_req), .eng_done(eng_done),
    .eng_addr(eng_addr), .eng_wr_data(eng_wr_data), .eng_grant(eng_grant),
    .sock_event_valid(sock_event_valid), .sock_event_idx(sock_event_idx),
    .sock_event_flags(sock_event_flags), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always @(negedge clk) begin
    if (sock_event_valid && ev_n < 16) begin
      ev_idx_log[ev_n]  = sock_event_idx;
      ev_flag_log[ev_n] = sock_event_flags;
      ev_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plays the w5300_interface side of one bus op: check the address, then complete it.
  task automatic bus_op(input string tag, input logic [10:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata, input bit chk_wr);
    @(negedge clk);
    check({tag, "_addr"}, 32'(ctrl_addr), 32'(addr));
    if (chk_wr) check({tag, "_wdata"}, 32'(ctrl_wr_data), 32'(wdata));
    ctrl_rd_data  = rdata;
    ctrl_op_state = 1'b1;
    @(negedge clk);
    ctrl_op_state = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    int cnt = 0;
    @(negedge clk);
    while (eng_grant == '0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(eng_grant), 32'(exp));
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int order[6] = '{0, 1, 3, 0, 1, 3};
    int cnt;
    rst_n = 1'b0; init_done = 1'b0; int_n = 1'b1; ctrl_rd_data = '0; ctrl_op_state = 1'b0;
    eng_req = '0; eng_done = '0; err_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      eng_addr[11*i +: 11]    = 11'h100 + 11'(i);
      eng_wr_data[16*i +: 16] = 16'ha000 + 16'(i);
    end
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(ctrl_addr), 32'h7fe);
    check("rst_ev", 32'(sock_event_valid), 0);
    rst_n = 1'b1;

    // Test 1: idle after init
    init_done = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_busy", 32'(busy), 0);
    check("t1_addr", 32'(ctrl_addr), 32'h7fe);
    check("t1_grant", 32'(eng_grant), 0);
    check("t1_err", 32'(err), 0);

    // Test 2: IR = 0x0005 -> sockets 0 and 2
    int_n = 1'b0;
    bus_op("t2_ir", 11'h402, 16'h0, 16'h0005, 1'b0);
    int_n = 1'b1;
    bus_op("t2_rd0", 11'h606, 16'h0, 16'h00f3, 1'b0);
    bus_op("t2_clr0", 11'h206, 16'h0013, 16'h0, 1'b1);
    bus_op("t2_rd2", 11'h686, 16'h0, 16'h0004, 1'b0);
    bus_op("t2_clr2", 11'h286, 16'h0004, 16'h0, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_busy", 32'(busy), 0);
    check("t2_ev_n", ev_n, 2);
    check("t2_ev0_idx", 32'(ev_idx_log[0]), 0);
    check("t2_ev0_flags", 32'(ev_flag_log[0]), 32'h13);
    check("t2_ev1_idx", 32'(ev_idx_log[1]), 2);
    check("t2_ev1_flags", 32'(ev_flag_log[1]), 32'h04);

    // Test 3: round-robin over requesters 0,1,3
    eng_req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      wait_grant($sformatf("t3_grant%0d", k), 4'(1 << order[k]));
      check($sformatf("t3_addr%0d", k), 32'(ctrl_addr), 32'h100 + order[k]);
      check($sformatf("t3_wr%0d", k), 32'(ctrl_wr_data), 32'ha000 + order[k]);
      if (k == 1) begin
        eng_done = 4'b0100;
        @(negedge clk);
        eng_done = '0;
        @(negedge clk);
        check("t3_foreign_done", 32'(eng_grant), 32'b0010);
      end
      @(negedge clk);
      eng_done = 4'(1 << order[k]);
      @(negedge clk);
      eng_done = '0;
      check($sformatf("t3_drop%0d", k), 32'(eng_grant), 0);
      if (k == 5) eng_req = '0;
    end

    // Test 4: IRQ wins over a simultaneous request
    @(negedge clk);
    eng_req = 4'b0100;
    int_n   = 1'b0;
    bus_op("t4_ir", 11'h402, 16'h0, 16'h0002, 1'b0);
    int_n = 1'b1;
    check("t4_nogrant", 32'(eng_grant), 0);
    bus_op("t4_rd1", 11'h646, 16'h0, 16'h00e0, 1'b0);
    bus_op("t4_clr1", 11'h246, 16'h0000, 16'h0, 1'b1);
    wait_grant("t4_grant", 4'b0100);
    check("t4_addr", 32'(ctrl_addr), 32'h102);
    check("t4_ev_n", ev_n, 3);
    check("t4_ev_idx", 32'(ev_idx_log[2]), 1);
    check("t4_ev_flags", 32'(ev_flag_log[2]), 0);
    eng_done = 4'b0100;
    @(negedge clk);
    eng_done = '0;
    eng_req  = '0;

    // Test 5: IR bits outside the socket range only
    @(negedge clk);
    int_n = 1'b0;
    bus_op("t5_ir", 11'h402, 16'h0, 16'h0090, 1'b0);
    int_n = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_addr", 32'(ctrl_addr), 32'h7fe);
    ctrl_op_state = 1'b1;
    @(negedge clk);
    ctrl_op_state = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_stale_busy", 32'(busy), 0);
    check("t5_ev_n", ev_n, 3);

    // Test 6: watchdog during RD_SNIR
    int_n = 1'b0;
    bus_op("t6_ir", 11'h402, 16'h0, 16'h0008, 1'b0);
    int_n = 1'b1;
    @(negedge clk);
    check("t6_addr", 32'(ctrl_addr), 32'h6c6);
    repeat (5900) @(negedge clk);
    check("t6_early_err", 32'(err), 0);
    check("t6_early_busy", 32'(busy), 1);
    cnt = 0;
    while (!err && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_err", 32'(err), 1);
    check("t6_err_addr", 32'(ctrl_addr), 32'h7fe);
    check("t6_err_grant", 32'(eng_grant), 0);
    init_done = 1'b0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t6_clr_err", 32'(err), 0);
    int_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_wait_addr", 32'(ctrl_addr), 32'h7fe);
    check("t6_wait_busy", 32'(busy), 0);
    int_n     = 1'b1;
    init_done = 1'b1;
    eng_req   = 4'b0001;
    wait_grant("t6_regrant", 4'b0001);
    eng_done = 4'b0001;
    @(negedge clk);
    eng_done = '0;
    eng_req  = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
